// File: rtl/ysyx_25010008_sram_slave_pkg.sv
// Shared definitions for the NPC memory responder: response codes, FSM encodings, default map base.
package ysyx_25010008_sram_slave_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] R_IDLE = 2'd0;
  localparam logic [1:0] R_WAIT = 2'd1;
  localparam logic [1:0] R_RESP = 2'd2;

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_WAIT = 2'd1;
  localparam logic [1:0] W_RESP = 2'd2;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h8000_0000;

  // Wide enough for any practical RD_LAT/WR_LAT plus the random extra delay.
  localparam int CNT_W = 16;

  function automatic logic [1:0] resp_for(input logic in_range);
    return in_range ? RESP_OKAY : RESP_DECERR;
  endfunction

endpackage

// File: rtl/ysyx_25010008_sram_slave_if.sv
// AXI4-Lite-style five-channel bus between the core master ports and the SRAM responder.
interface ysyx_25010008_sram_slave_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              arvalid;
  logic              arready;
  logic [ADDR_W-1:0] araddr;
  logic              rvalid;
  logic              rready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              awvalid;
  logic              awready;
  logic [ADDR_W-1:0] awaddr;
  logic              wvalid;
  logic              wready;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic              bvalid;
  logic              bready;
  logic [1:0]        bresp;

  modport master (
    output arvalid, araddr, rready, awvalid, awaddr, wvalid, wdata, wstrb, bready,
    input  arready, rvalid, rdata, rresp, awready, wready, bvalid, bresp
  );

  modport slave (
    input  arvalid, araddr, rready, awvalid, awaddr, wvalid, wdata, wstrb, bready,
    output arready, rvalid, rdata, rresp, awready, wready, bvalid, bresp
  );
endinterface

// File: rtl/ysyx_25010008_sram_slave_lfsr8.sv
// 8-bit Fibonacci LFSR (taps 8,6,5,4) driving random response delays.
// Only compiled when SRAM_SLAVE_RAND_DELAY_EN is defined.
`ifdef SRAM_SLAVE_RAND_DELAY_EN
module ysyx_25010008_lfsr8 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  output logic [7:0] q
);
  logic [7:0] q_q;
  logic [7:0] q_d;

  assign q_d = en ? {q_q[6:0], q_q[7] ^ q_q[5] ^ q_q[4] ^ q_q[3]} : q_q;
  assign q   = q_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q_q <= 8'hA5;
    else        q_q <= q_d;
  end
endmodule
`endif

// File: rtl/ysyx_25010008_sram_slave.sv
// Word-addressed SRAM responder with independent read/write FSMs and configurable latency.
// Define SRAM_SLAVE_RAND_DELAY_EN to add LFSR-driven random extra wait cycles.
module ysyx_25010008_sram_slave
  import ysyx_25010008_sram_slave_pkg::*;
#(
  parameter int              ADDR_W      = 32,
  parameter int              DATA_W      = 32,
  parameter int              DEPTH_WORDS = 4096,
  parameter logic [ADDR_W-1:0] BASE_ADDR = DEFAULT_BASE_ADDR,
  parameter int              RD_LAT      = 1,
  parameter int              WR_LAT      = 1
) (
  input  logic clk,
  input  logic rst_n,
  ysyx_25010008_sram_slave_if.slave bus
);
  localparam int              IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [ADDR_W:0] SPAN  = (ADDR_W+1)'(4 * DEPTH_WORDS);

  // A borrow on subtraction sets the top bit, so below-base addresses fail the compare too.
  function automatic logic hit(input logic [ADDR_W-1:0] a);
    logic [ADDR_W:0] off;
    off = {1'b0, a} - {1'b0, BASE_ADDR};
    return off < SPAN;
  endfunction

  function automatic logic [IDX_W-1:0] idx_of(input logic [ADDR_W-1:0] a);
    return IDX_W'((a - BASE_ADDR) >> 2);
  endfunction

  logic [DATA_W-1:0] mem [DEPTH_WORDS];

  logic [CNT_W-1:0] rd_extra, wr_extra;
`ifdef SRAM_SLAVE_RAND_DELAY_EN
  logic [7:0] lfsr;
  ysyx_25010008_lfsr8 u_lfsr (.clk(clk), .rst_n(rst_n), .en(1'b1), .q(lfsr));
  assign rd_extra = CNT_W'(lfsr[2:0]);
  assign wr_extra = CNT_W'(lfsr[5:3]);
`else
  assign rd_extra = '0;
  assign wr_extra = '0;
`endif

  logic [1:0]        r_state_q, r_state_d;
  logic [CNT_W-1:0]  r_cnt_q, r_cnt_d;
  logic [ADDR_W-1:0] r_addr_q, r_addr_d;
  logic              arready_q, arready_d, rvalid_q, rvalid_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [1:0]        rresp_q, rresp_d;

  always_comb begin
    r_state_d = r_state_q;
    r_cnt_d   = r_cnt_q;
    r_addr_d  = r_addr_q;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    case (r_state_q)
      R_IDLE: begin
        if (arready_q && bus.arvalid) begin
          r_addr_d  = bus.araddr;
          arready_d = 1'b0;
          r_cnt_d   = CNT_W'(RD_LAT - 1) + rd_extra;
          r_state_d = R_WAIT;
        end else begin
          arready_d = 1'b1;
        end
      end
      R_WAIT: begin
        if (r_cnt_q == '0) begin
          rvalid_d  = 1'b1;
          rresp_d   = resp_for(hit(r_addr_q));
          rdata_d   = hit(r_addr_q) ? mem[idx_of(r_addr_q)] : '0;
          r_state_d = R_RESP;
        end else begin
          r_cnt_d = r_cnt_q - 1'b1;
        end
      end
      R_RESP: begin
        if (bus.rready) begin
          rvalid_d  = 1'b0;
          arready_d = 1'b1;
          r_state_d = R_IDLE;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state_q <= R_IDLE;
      r_cnt_q   <= '0;
      r_addr_q  <= '0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= '0;
    end else begin
      r_state_q <= r_state_d;
      r_cnt_q   <= r_cnt_d;
      r_addr_q  <= r_addr_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

  logic [1:0]          w_state_q, w_state_d;
  logic [CNT_W-1:0]    w_cnt_q, w_cnt_d;
  logic [ADDR_W-1:0]   aw_addr_q, aw_addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W/8-1:0] wstrb_q, wstrb_d;
  logic                aw_got_q, aw_got_d, w_got_q, w_got_d;
  logic                awready_q, awready_d, wready_q, wready_d;
  logic                bvalid_q, bvalid_d;
  logic [1:0]          bresp_q, bresp_d;
  logic                mem_we;

  // Readies are only high in W_IDLE, so these handshakes cannot fire elsewhere.
  always_comb begin
    w_state_d = w_state_q;
    w_cnt_d   = w_cnt_q;
    aw_addr_d = aw_addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    aw_got_d  = aw_got_q;
    w_got_d   = w_got_q;
    awready_d = awready_q;
    wready_d  = wready_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    case (w_state_q)
      W_IDLE: begin
        if (awready_q && bus.awvalid) begin
          aw_addr_d = bus.awaddr;
          aw_got_d  = 1'b1;
        end
        if (wready_q && bus.wvalid) begin
          wdata_d = bus.wdata;
          wstrb_d = bus.wstrb;
          w_got_d = 1'b1;
        end
        if (aw_got_d && w_got_d) begin
          aw_got_d  = 1'b0;
          w_got_d   = 1'b0;
          awready_d = 1'b0;
          wready_d  = 1'b0;
          w_cnt_d   = CNT_W'(WR_LAT - 1) + wr_extra;
          w_state_d = W_WAIT;
        end else begin
          awready_d = !aw_got_d;
          wready_d  = !w_got_d;
        end
      end
      W_WAIT: begin
        if (w_cnt_q == '0) begin
          bvalid_d  = 1'b1;
          bresp_d   = resp_for(hit(aw_addr_q));
          w_state_d = W_RESP;
        end else begin
          w_cnt_d = w_cnt_q - 1'b1;
        end
      end
      W_RESP: begin
        if (bus.bready) begin
          bvalid_d  = 1'b0;
          awready_d = 1'b1;
          wready_d  = 1'b1;
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state_q <= W_IDLE;
      w_cnt_q   <= '0;
      aw_addr_q <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      aw_got_q  <= 1'b0;
      w_got_q   <= 1'b0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= '0;
    end else begin
      w_state_q <= w_state_d;
      w_cnt_q   <= w_cnt_d;
      aw_addr_q <= aw_addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      aw_got_q  <= aw_got_d;
      w_got_q   <= w_got_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
    end
  end

  // Commit shares the edge with a read sample; nonblocking update keeps the read on old data.
  assign mem_we = (w_state_q == W_WAIT) && (w_cnt_q == '0) && hit(aw_addr_q);

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < DATA_W/8; i++) begin
        if (wstrb_q[i]) mem[idx_of(aw_addr_q)][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

  assign bus.arready = arready_q;
  assign bus.rvalid  = rvalid_q;
  assign bus.rdata   = rdata_q;
  assign bus.rresp   = rresp_q;
  assign bus.awready = awready_q;
  assign bus.wready  = wready_q;
  assign bus.bvalid  = bvalid_q;
  assign bus.bresp   = bresp_q;

endmodule

// File: tb/tb_ysyx_25010008_sram_slave.sv
// Randomized self-checking bench for the SRAM responder against an array-based memory model.
module tb_ysyx_25010008_sram_slave;
  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam int          DEPTH = 4096;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ysyx_25010008_sram_slave_if #(.ADDR_W(32), .DATA_W(32)) bus ();
  ysyx_25010008_sram_slave_if #(.ADDR_W(32), .DATA_W(32)) bus3 ();

  ysyx_25010008_sram_slave dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  ysyx_25010008_sram_slave #(.RD_LAT(3), .WR_LAT(2)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] ref_mem [DEPTH];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Exact latency by default; with random delay any value in [base, base+7] is acceptable.
  function automatic int lat_exp(input int got, input int base);
`ifdef SRAM_SLAVE_RAND_DELAY_EN
    return (got >= base && got <= base + 7) ? got : base;
`else
    return base + (got & 0);
`endif
  endfunction

  function automatic bit in_map(input logic [31:0] a);
    return a >= BASE && a < BASE + 32'(4 * DEPTH);
  endfunction

  function automatic int idx(input logic [31:0] a);
    return int'((a - BASE) >> 2);
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    if (in_map(a))
      for (int i = 0; i < 4; i++) if (s[i]) ref_mem[idx(a)][8*i +: 8] = d[8*i +: 8];
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] a);
    return in_map(a) ? ref_mem[idx(a)] : 32'h0;
  endfunction

  // w_lead > 0: W raised that many cycles before AW; w_lead < 0: AW leads.
  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int w_lead, input int b_hold,
                           output logic [1:0] resp, output int lat);
    int t;
    bit aw_done, w_done, aw_hs, w_hs;
    bus.awaddr = a; bus.wdata = d; bus.wstrb = s;
    bus.awvalid = (w_lead <= 0);
    bus.wvalid  = (w_lead >= 0);
    aw_done = 0; w_done = 0; t = 0;
    while (!(aw_done && w_done) && t < 50) begin
      aw_hs = bus.awvalid && bus.awready;
      w_hs  = bus.wvalid && bus.wready;
      @(posedge clk); #1; t++;
      if (aw_hs) begin aw_done = 1; bus.awvalid = 1'b0; end
      if (w_hs)  begin w_done  = 1; bus.wvalid  = 1'b0; end
      if (!aw_done && t >= w_lead)  bus.awvalid = 1'b1;
      if (!w_done  && t >= -w_lead) bus.wvalid  = 1'b1;
    end
    if (!(aw_done && w_done)) check_eq("aw_w_timeout", 32'(t), 32'd0);
    lat = 0;
    while (!bus.bvalid && lat < 50) begin @(posedge clk); #1; lat++; end
    if (!bus.bvalid) check_eq("b_timeout", 32'(lat), 32'd0);
    resp = bus.bresp;
    for (int i = 0; i < b_hold; i++) begin
      @(posedge clk); #1;
      check_eq("b_hold_valid", 32'(bus.bvalid), 32'd1);
      check_eq("b_hold_resp", 32'(bus.bresp), 32'(resp));
      check_eq("b_hold_awready", 32'(bus.awready), 32'd0);
    end
    bus.bready = 1'b1;
    @(posedge clk); #1;
    bus.bready = 1'b0;
    check_eq("b_done", 32'(bus.bvalid), 32'd0);
  endtask

  task automatic axi_read(input logic [31:0] a, input int r_hold,
                          output logic [31:0] data, output logic [1:0] resp, output int lat);
    int t;
    bit hs;
    bus.araddr = a; bus.arvalid = 1'b1; t = 0;
    do begin
      hs = bus.arready;
      @(posedge clk); #1; t++;
    end while (!hs && t < 50);
    bus.arvalid = 1'b0;
    if (!hs) check_eq("ar_timeout", 32'(t), 32'd0);
    lat = 0;
    while (!bus.rvalid && lat < 50) begin @(posedge clk); #1; lat++; end
    if (!bus.rvalid) check_eq("r_timeout", 32'(lat), 32'd0);
    data = bus.rdata; resp = bus.rresp;
    for (int i = 0; i < r_hold; i++) begin
      @(posedge clk); #1;
      check_eq("r_hold_valid", 32'(bus.rvalid), 32'd1);
      check_eq("r_hold_data", bus.rdata, data);
      check_eq("r_hold_arready", 32'(bus.arready), 32'd0);
    end
    bus.rready = 1'b1;
    @(posedge clk); #1;
    bus.rready = 1'b0;
    check_eq("r_done", 32'(bus.rvalid), 32'd0);
  endtask

  task automatic wr_chk(input string tag, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, input int w_lead, input int b_hold);
    logic [1:0] resp;
    int lat;
    axi_write(a, d, s, w_lead, b_hold, resp, lat);
    check_eq({tag, "_bresp"}, 32'(resp), in_map(a) ? 32'd0 : 32'd3);
    check_eq({tag, "_wlat"}, 32'(lat), 32'(lat_exp(lat, 1)));
    model_write(a, d, s);
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] a, input int r_hold);
    logic [31:0] d;
    logic [1:0] resp;
    int lat;
    axi_read(a, r_hold, d, resp, lat);
    check_eq({tag, "_rdata"}, d, model_read(a));
    check_eq({tag, "_rresp"}, 32'(resp), in_map(a) ? 32'd0 : 32'd3);
    check_eq({tag, "_rlat"}, 32'(lat), 32'(lat_exp(lat, 1)));
  endtask

  task automatic bus_idle();
    bus.arvalid = 0; bus.araddr = '0; bus.rready = 0; bus.awvalid = 0; bus.awaddr = '0;
    bus.wvalid = 0; bus.wdata = '0; bus.wstrb = '0; bus.bready = 0;
    bus3.arvalid = 0; bus3.araddr = '0; bus3.rready = 0; bus3.awvalid = 0; bus3.awaddr = '0;
    bus3.wvalid = 0; bus3.wdata = '0; bus3.wstrb = '0; bus3.bready = 0;
  endtask

  task automatic check_post_reset(input string tag);
    check_eq({tag, "_arready_low"}, 32'(bus.arready), 32'd0);
    @(posedge clk); #1;
    check_eq({tag, "_readies"}, {29'd0, bus.arready, bus.awready, bus.wready}, 32'h7);
    check_eq({tag, "_no_valids"}, {30'd0, bus.rvalid, bus.bvalid}, 32'h0);
  endtask

  initial begin
    logic [31:0] a, d, old_w;
    int l, rc, bc;

    bus_idle();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_outputs", {27'd0, bus.arready, bus.awready, bus.wready, bus.rvalid, bus.bvalid}, 32'h0);
    check_eq("reset_data", {bus.rdata[29:0], bus.rresp}, 32'h0);
    rst_n = 1'b1;
    check_post_reset("rel1");

    wr_chk("wr_basic", 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 0, 0);
    rd_chk("rd_basic", 32'h8000_0010, 0);

    wr_chk("preload", 32'h8000_0020, 32'h1122_3344, 4'hF, 0, 0);
    wr_chk("strobe", 32'h8000_0020, 32'hAABB_CCDD, 4'b0101, 0, 0);
    check_eq("strobe_model", model_read(32'h8000_0020), 32'h11BB_33DD);
    rd_chk("rd_strobe", 32'h8000_0020, 1);

    wr_chk("w_first", 32'h8000_0030, 32'h0BAD_CAFE, 4'hF, 3, 5);
    wr_chk("aw_first", 32'h8000_0034, 32'h1234_5678, 4'hF, -2, 0);
    wr_chk("zero_strb", 32'h8000_0030, 32'hFFFF_FFFF, 4'h0, 0, 0);
    rd_chk("rd_w_first", 32'h8000_0030, 0);
    rd_chk("rd_aw_first", 32'h8000_0036, 2);

    rd_chk("decerr_rd", 32'h7FFF_FFFC, 0);
    wr_chk("base_word", 32'h8000_0000, 32'h5A5A_A5A5, 4'hF, 0, 0);
    wr_chk("decerr_wr", 32'h8000_4000, 32'hFFFF_0000, 4'hF, 0, 0);
    rd_chk("rd_after_decerr", 32'h8000_0000, 0);

    // Read and write of the same word launched on the same edge.
    a = 32'h8000_0040;
    wr_chk("coll_pre", a, 32'h0101_0101, 4'hF, 0, 0);
    old_w = model_read(a);
    d = 32'hFEED_FACE;
    bus.araddr = a; bus.arvalid = 1; bus.awaddr = a; bus.awvalid = 1;
    bus.wdata = d; bus.wstrb = 4'hF; bus.wvalid = 1;
    @(posedge clk); #1;
    bus.arvalid = 0; bus.awvalid = 0; bus.wvalid = 0;
    check_eq("coll_taken", {30'd0, bus.arready, bus.awready}, 32'h0);
    rc = 0; bc = 0;
    for (int c = 1; c <= 50 && (rc == 0 || bc == 0); c++) begin
      @(posedge clk); #1;
      if (rc == 0 && bus.rvalid) rc = c;
      if (bc == 0 && bus.bvalid) bc = c;
    end
    check_eq("coll_rdata", bus.rdata, (rc != 0 && rc <= bc) ? old_w : d);
    check_eq("coll_rlat", 32'(rc), 32'(lat_exp(rc, 1)));
    bus.rready = 1; bus.bready = 1;
    @(posedge clk); #1;
    bus.rready = 0; bus.bready = 0;
    model_write(a, d, 4'hF);
    rd_chk("coll_after", a, 0);

    // Longer-latency instance: RD_LAT=3, WR_LAT=2.
    check_eq("lat3_ready", {29'd0, bus3.arready, bus3.awready, bus3.wready}, 32'h7);
    bus3.awaddr = 32'h8000_0100; bus3.awvalid = 1; bus3.wdata = 32'hCAFE_F00D;
    bus3.wstrb = 4'hF; bus3.wvalid = 1;
    @(posedge clk); #1;
    bus3.awvalid = 0; bus3.wvalid = 0;
    l = 0;
    while (!bus3.bvalid && l < 50) begin @(posedge clk); #1; l++; end
    check_eq("lat3_wlat", 32'(l), 32'(lat_exp(l, 2)));
    check_eq("lat3_bresp", 32'(bus3.bresp), 32'd0);
    bus3.bready = 1; @(posedge clk); #1; bus3.bready = 0;
    bus3.araddr = 32'h8000_0100; bus3.arvalid = 1;
    @(posedge clk); #1;
    bus3.arvalid = 0;
    l = 0;
    while (!bus3.rvalid && l < 50) begin @(posedge clk); #1; l++; end
    check_eq("lat3_rlat", 32'(l), 32'(lat_exp(l, 3)));
    check_eq("lat3_rdata", bus3.rdata, 32'hCAFE_F00D);
    bus3.rready = 1; @(posedge clk); #1; bus3.rready = 0;

    for (int i = 0; i < 64; i++)
      wr_chk("rnd_pre", 32'h8000_1000 + 32'(4 * i), $urandom, 4'hF, 0, 0);

    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 9) == 0)
        a = ($urandom_range(0, 1) == 0) ? 32'h8000_4000 + 32'(4 * $urandom_range(0, 15))
                                        : 32'h7FFF_FFF0 + 32'($urandom_range(0, 15));
      else
        a = 32'h8000_1000 + 32'(4 * $urandom_range(0, 63)) + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 0)
        wr_chk("rnd_wr", a, $urandom, 4'($urandom_range(0, 15)),
               int'($urandom_range(0, 4)) - 2, int'($urandom_range(0, 2)));
      else
        rd_chk("rnd_rd", a, int'($urandom_range(0, 2)));
    end

    // Reset while a read response is pending.
    bus.araddr = 32'h8000_1000; bus.arvalid = 1;
    @(posedge clk); #1;
    bus.arvalid = 0;
    l = 0;
    while (!bus.rvalid && l < 50) begin @(posedge clk); #1; l++; end
    check_eq("pre_reset_rvalid", 32'(bus.rvalid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("async_reset", {29'd0, bus.rvalid, bus.arready, bus.awready}, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    check_post_reset("rel2");
    rd_chk("mem_kept", 32'h8000_1000, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got %0d checks, expected completion", n_checks);
    $fatal(1, "timeout");
  end
endmodule
